// File: rtl/snake_motion_if.sv
// Bundles the command inputs, status outputs and renderer read port of snake_motion.
// The game logic uses the slave modport; whoever drives commands uses master.
interface snake_motion_if #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int MAX_LEN = 16
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  logic [2:0]    direction;
  logic [1:0]    mode;
  logic          pause;
  logic          rst1;
  logic          grow;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] len;
  logic          step_pulse;
  logic          game_over;
  logic [IW-1:0] rd_idx;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_valid;

  modport master (
    output direction, mode, pause, rst1, grow, rd_idx,
    input  head_x, head_y, len, step_pulse, game_over, rd_x, rd_y, rd_valid
  );

  modport slave (
    input  direction, mode, pause, rst1, grow, rd_idx,
    output head_x, head_y, len, step_pulse, game_over, rd_x, rd_y, rd_valid
  );
endinterface

// File: rtl/snake_motion.sv
// Snake game motion engine: steps the snake on a grid at a mode-selected rate,
// tracks body segments and growth, and flags wall/self collisions.
module snake_motion #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int MAX_LEN   = 16,
  parameter int START_X   = 8,
  parameter int START_Y   = 12,
  parameter int START_LEN = 3,
  parameter int PERIOD0   = 12_500_000,
  parameter int PERIOD1   = 8_333_333,
  parameter int PERIOD2   = 6_250_000,
  parameter int PERIOD3   = 4_166_666
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  snake_motion_if.slave bus
);
  localparam int XW     = $clog2(GRID_W);
  localparam int YW     = $clog2(GRID_H);
  localparam int LW     = $clog2(MAX_LEN + 1);
  localparam int PMAX01 = (PERIOD0 > PERIOD1) ? PERIOD0 : PERIOD1;
  localparam int PMAX23 = (PERIOD2 > PERIOD3) ? PERIOD2 : PERIOD3;
  localparam int PMAX   = (PMAX01 > PMAX23) ? PMAX01 : PMAX23;
  localparam int CW     = $clog2(PMAX + 1);

  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    heading_q, heading_d;
  logic          grow_pend_q, grow_pend_d;
  logic          step_pulse_q, step_pulse_d;
  logic          game_over_q, game_over_d;
  logic [LW-1:0] len_q, len_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];

  logic [CW-1:0]      period_m1;
  logic [2:0]         new_heading;
  logic [2:0]         opposite;
  logic [XW-1:0]      next_x;
  logic [YW-1:0]      next_y;
  logic               wall_hit;
  logic               self_hit;
  logic [LW-1:0]      self_lim;
  logic [MAX_LEN-1:0] seg_hit;

  // Starting body: a horizontal line trailing left of the head, unused slots zero.
  function automatic logic [XW-1:0] init_x(input int i);
    return (i < START_LEN) ? XW'(START_X - i) : '0;
  endfunction

  function automatic logic [YW-1:0] init_y(input int i);
    return (i < START_LEN) ? YW'(START_Y) : '0;
  endfunction

  // Step period (minus one) for the currently selected speed mode.
  always_comb begin
    case (bus.mode)
      2'd0:    period_m1 = CW'(PERIOD0 - 1);
      2'd1:    period_m1 = CW'(PERIOD1 - 1);
      2'd2:    period_m1 = CW'(PERIOD2 - 1);
      default: period_m1 = CW'(PERIOD3 - 1);
    endcase
  end

  // Accept a new heading only for valid codes that do not reverse onto the neck.
  always_comb begin
    case (heading_q)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      default:   opposite = DIR_LEFT;
    endcase
    new_heading = heading_q;
    if (bus.direction >= DIR_UP && bus.direction <= DIR_RIGHT && bus.direction != opposite)
      new_heading = bus.direction;
  end

  // Candidate head position and wall check; no wrap-around at the edges.
  always_comb begin
    next_x   = seg_x_q[0];
    next_y   = seg_y_q[0];
    wall_hit = 1'b0;
    case (new_heading)
      DIR_UP:   if (seg_y_q[0] == '0) wall_hit = 1'b1; else next_y = seg_y_q[0] - 1'b1;
      DIR_DOWN: if (seg_y_q[0] == YW'(GRID_H - 1)) wall_hit = 1'b1; else next_y = seg_y_q[0] + 1'b1;
      DIR_LEFT: if (seg_x_q[0] == '0) wall_hit = 1'b1; else next_x = seg_x_q[0] - 1'b1;
      default:  if (seg_x_q[0] == XW'(GRID_W - 1)) wall_hit = 1'b1; else next_x = seg_x_q[0] + 1'b1;
    endcase
  end

  // The tail vacates its cell on a normal step, so it is excluded unless the snake grows.
  assign self_lim = (grow_pend_q && len_q < LW'(MAX_LEN)) ? len_q : len_q - 1'b1;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_hit
      assign seg_hit[gi] = (LW'(gi) < self_lim) && (seg_x_q[gi] == next_x) && (seg_y_q[gi] == next_y);
    end
  endgenerate

  assign self_hit = |seg_hit;

  // Next-state logic: restart, idle/run/over sequencing, step and growth handling.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    heading_d    = heading_q;
    grow_pend_d  = grow_pend_q;
    step_pulse_d = 1'b0;
    game_over_d  = game_over_q;
    len_d        = len_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_d[i] = seg_x_q[i];
      seg_y_d[i] = seg_y_q[i];
    end

    if (!bus.rst1) begin
      state_d     = IDLE;
      cnt_d       = '0;
      heading_d   = DIR_RIGHT;
      grow_pend_d = 1'b0;
      game_over_d = 1'b0;
      len_d       = LW'(START_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = init_x(i);
        seg_y_d[i] = init_y(i);
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.grow) grow_pend_d = 1'b1;
          if (!bus.pause) state_d = RUN;
        end
        RUN: begin
          if (bus.grow) grow_pend_d = 1'b1;
          if (bus.pause) begin
            state_d = IDLE;
          end else if (cnt_q >= period_m1) begin
            cnt_d     = '0;
            heading_d = new_heading;
            if (wall_hit || self_hit) begin
              state_d     = OVER;
              game_over_d = 1'b1;
            end else begin
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_d[i] = seg_x_q[i-1];
                seg_y_d[i] = seg_y_q[i-1];
              end
              seg_x_d[0]   = next_x;
              seg_y_d[0]   = next_y;
              step_pulse_d = 1'b1;
              if (grow_pend_q && len_q < LW'(MAX_LEN)) len_d = len_q + 1'b1;
              // A grow arriving on the step cycle is kept for the following step.
              grow_pend_d = bus.grow;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous game initialisation.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      heading_q    <= DIR_RIGHT;
      grow_pend_q  <= 1'b0;
      step_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
      len_q        <= LW'(START_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      heading_q    <= heading_d;
      grow_pend_q  <= grow_pend_d;
      step_pulse_q <= step_pulse_d;
      game_over_q  <= game_over_d;
      len_q        <= len_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_d[i];
        seg_y_q[i] <= seg_y_d[i];
      end
    end
  end

  assign bus.head_x     = seg_x_q[0];
  assign bus.head_y     = seg_y_q[0];
  assign bus.len        = len_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.game_over  = game_over_q;
  assign bus.rd_x       = seg_x_q[bus.rd_idx];
  assign bus.rd_y       = seg_y_q[bus.rd_idx];
  assign bus.rd_valid   = LW'(bus.rd_idx) < len_q;
endmodule
